// File: rtl/vga_pll_reset_ctrl.sv
// vga_pll_reset_ctrl: pixel-clock PLL reset/lock sequencer with timeout, bounded retries and lock-loss handling.
// Define PLL_RELOCK_EN to re-reset the PLL on lock loss in RUN; otherwise the sequencer just waits for relock.
module vga_pll_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic       fail
);
  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_WAIT = 3'd1,
    S_STAB = 3'd2,
    S_RUN  = 3'd3,
    S_FAIL = 3'd4
  } state_t;
  localparam logic [CNT_W-1:0] RST_END   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_END  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [3:0]       r_retry, w_retry_nx;
  logic [7:0]       r_loss, w_loss_nx;
  logic [1:0]       r_sync;
  logic             r_pll_rst, r_sys_rst_n, r_fail;
  logic             w_lock_s;
  assign w_lock_s      = r_sync[1];
  assign state         = r_state;
  assign retry_cnt     = r_retry;
  assign lock_loss_cnt = r_loss;
  assign pll_rst       = r_pll_rst;
  assign sys_rst_n     = r_sys_rst_n;
  assign fail          = r_fail;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + CNT_W'(1);
    w_retry_nx = r_retry;
    w_loss_nx  = r_loss;
    if (restart) begin
      w_state_nx = S_RST;
      w_cnt_nx   = '0;
      w_retry_nx = '0;
    end else begin
      case (r_state)
        S_RST: if (r_cnt == RST_END) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = '0;
        end
        S_WAIT: if (w_lock_s) begin
          w_state_nx = S_STAB;
          w_cnt_nx   = '0;
        end else if (r_cnt == TO_END) begin
          w_cnt_nx   = '0;
          w_state_nx = (r_retry == RETRY_MAX) ? S_FAIL : S_RST;
          w_retry_nx = (r_retry == RETRY_MAX) ? r_retry : r_retry + 4'd1;
        end
        S_STAB: if (!w_lock_s) begin
          w_state_nx = S_WAIT;
          w_cnt_nx   = '0;
        end else if (r_cnt == STAB_END) begin
          w_state_nx = S_RUN;
          w_cnt_nx   = '0;
          w_retry_nx = '0;
        end
        S_RUN: begin
          w_cnt_nx = '0;
          if (!w_lock_s) begin
            w_loss_nx = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
`ifdef PLL_RELOCK_EN
            w_state_nx = S_RST;
            w_retry_nx = '0;
`else
            w_state_nx = S_WAIT;
`endif
          end
        end
        S_FAIL: w_cnt_nx = '0;
        default: begin
          w_state_nx = S_RST;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end
  // Output flops are loaded from the next state so they change on the same edge as state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync      <= '0;
      r_state     <= S_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], pll_locked};
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_retry     <= w_retry_nx;
      r_loss      <= w_loss_nx;
      r_pll_rst   <= (w_state_nx == S_RST) || (w_state_nx == S_FAIL);
      r_sys_rst_n <= (w_state_nx == S_RUN);
      r_fail      <= (w_state_nx == S_FAIL);
    end
  end
endmodule

// File: tb/tb_vga_pll_reset_ctrl.sv
// tb_vga_pll_reset_ctrl: scoreboard bench with a phase/elapsed-time reference model of the sequencer.
module tb_vga_pll_reset_ctrl;
  localparam int RC = 4, LT = 100, SC = 8, MR = 2;
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
  logic refclk = 1'b0, rst_n = 1'b1, pll_locked = 1'b0, restart = 1'b0;
  logic pll_rst, sys_rst_n, fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [17:0] w_dut;
  int n_chk = 0, n_pass = 0, cyc_no = 0;
  int m_phase, m_t, m_retry, m_loss;
  logic m_h1, m_h2;
  logic [17:0] exp_q[$];

  always #5 refclk = ~refclk;

  vga_pll_reset_ctrl #(.RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
                       .MAX_RETRIES(MR), .CNT_W(8)) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .state(state), .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt), .fail(fail));

  assign w_dut = {pll_rst, sys_rst_n, state, retry_cnt, lock_loss_cnt, fail};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [17:0] m_out();
    return {m_phase == P_RST || m_phase == P_FAIL, m_phase == P_RUN, 3'(m_phase),
            4'(m_retry), 8'(m_loss), m_phase == P_FAIL};
  endfunction

  task automatic model_reset();
    m_phase = P_RST; m_t = 0; m_retry = 0; m_loss = 0; m_h1 = 0; m_h2 = 0;
  endtask

  // One clock edge of the sequencer's rules; lock as seen by the FSM is pll_locked two edges old.
  task automatic model_step(input logic lk, input logic rs);
    logic ls;
    ls = m_h2; m_h2 = m_h1; m_h1 = lk;
    if (rs) begin
      m_phase = P_RST; m_t = 0; m_retry = 0;
    end else case (m_phase)
      P_RST: begin
        m_t++;
        if (m_t == RC) begin m_phase = P_WAIT; m_t = 0; end
      end
      P_WAIT: if (ls) begin
        m_phase = P_STAB; m_t = 0;
      end else begin
        m_t++;
        if (m_t == LT) begin
          m_t = 0;
          if (m_retry == MR) m_phase = P_FAIL;
          else begin m_retry++; m_phase = P_RST; end
        end
      end
      P_STAB: if (!ls) begin
        m_phase = P_WAIT; m_t = 0;
      end else begin
        m_t++;
        if (m_t == SC) begin m_phase = P_RUN; m_retry = 0; end
      end
      P_RUN: if (!ls) begin
        if (m_loss < 255) m_loss++;
        m_t = 0;
`ifdef PLL_RELOCK_EN
        m_phase = P_RST; m_retry = 0;
`else
        m_phase = P_WAIT;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic cyc(input logic lk, input logic rs);
    pll_locked = lk; restart = rs;
    @(posedge refclk); #1;
    model_step(lk, rs);
    exp_q.push_back(m_out());
    cyc_no++;
    @(negedge refclk);
  endtask

  task automatic do_reset();
    #2;
    exp_q.delete();
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    #1;
    model_reset();
    chk("async reset outputs", w_dut, m_out());
    @(negedge refclk); #2;
    rst_n = 1'b1;
  endtask

  initial forever begin
    @(negedge refclk);
    if (exp_q.size() > 0) chk($sformatf("cycle %0d outputs", cyc_no), w_dut, exp_q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int k, rose, saw;
    // Power-up: lock from cycle 10, release 11 edges later
    do_reset();
    repeat (10) cyc(1'b0, 1'b0);
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b0);
      if (sys_rst_n && k == 0) k = i;
    end
    chk("lock-to-release edges", k, 11);
    chk("retry after power-up", retry_cnt, 0);
    // Lock loss in RUN
    k = 0;
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 1'b0);
      if (!sys_rst_n && k == 0) k = i;
    end
    chk("lock-loss to sys_rst_n low edges", k, 3);
    chk("lock_loss_cnt after one loss", lock_loss_cnt, 1);
`ifdef PLL_RELOCK_EN
    chk("state after loss", state, 0);
`else
    chk("state after loss", state, 1);
    chk("pll_rst after loss", pll_rst, 0);
`endif
    repeat (16) cyc(1'b1, 1'b0);
    chk("state after relock", state, 3);
    // Saturate lock-loss counter
    repeat (256) begin
      repeat (3) cyc(1'b0, 1'b0);
      repeat (16) cyc(1'b1, 1'b0);
    end
    chk("lock_loss_cnt saturated", lock_loss_cnt, 255);
    // Restart then no lock: three attempts, then FAIL
    cyc(1'b0, 1'b1);
    k = 0; rose = 0;
    for (int i = 1; i <= 400 && k == 0; i++) begin
      cyc(1'b0, 1'b0);
      if (sys_rst_n) rose = 1;
      if (fail) k = i;
    end
    chk("edges to FAIL", k, 3 * (RC + LT));
    chk("retry_cnt in FAIL", retry_cnt, MR);
    chk("pll_rst in FAIL", pll_rst, 1);
    chk("no release while failing", rose, 0);
    repeat (5) cyc(1'b1, 1'b0);
    chk("FAIL holds", state, 4);
    // Restart out of FAIL keeps loss count
    cyc(1'b1, 1'b1);
    chk("state after restart", state, 0);
    chk("fail after restart", fail, 0);
    chk("retry after restart", retry_cnt, 0);
    chk("loss kept over restart", lock_loss_cnt, 255);
    // One-cycle lock glitch during STAB
    do_reset();
    repeat (10) cyc(1'b0, 1'b0);
    rose = 0;
    repeat (6) begin
      cyc(1'b1, 1'b0);
      if (sys_rst_n) rose = 1;
    end
    cyc(1'b0, 1'b0);
    k = 0; saw = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 1'b0);
      if (state == 3'd1) saw = 1;
      if (sys_rst_n && k == 0) k = i;
    end
    chk("no early release", rose, 0);
    chk("glitch returns to WAIT", saw, 1);
    chk("release edges after glitch", k, 11);
    // Randomized lock and restart activity
    for (int s = 0; s < 40; s++) begin
      logic lk;
      int len;
      lk = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 25);
      for (int i = 0; i < len; i++) cyc(lk, $urandom_range(0, 60) == 0);
    end
    // Asynchronous reset mid-STAB and mid-RUN
    do_reset();
    repeat (10) cyc(1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0);
    chk("in STAB before reset", state, 2);
    do_reset();
    repeat (10) cyc(1'b0, 1'b0);
    repeat (20) cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    repeat (16) cyc(1'b1, 1'b0);
    chk("in RUN before reset", state, 3);
    do_reset();
    chk("loss cleared by reset", lock_loss_cnt, 0);
    repeat (3) cyc(1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
